// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: operating-mode encoding shared by the universal shift register and its bit cells.
// Rev 1.0
`default_nettype none

package univ_shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

endpackage

`default_nettype wire

// File: rtl/shift_reg_cell.sv
// shift_reg_cell: one register bit, sync-reset DFF with hold / from-higher / from-lower / load mux.
// Rev 1.0
`default_nettype none

module shift_reg_cell
   import univ_shift_reg_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  mode_t sel,
   input  logic  from_hi,
   input  logic  from_lo,
   input  logic  load_bit,
   output logic  q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case (sel)
            MODE_HOLD: q <= q;
            MODE_SHR:  q <= from_hi;
            MODE_SHL:  q <= from_lo;
            MODE_LOAD: q <= load_bit;
            default:   q <= q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised bidirectional shift register with parallel load, shift counter and word pulse.
// Optional macro UNIV_SHIFT_REG_ROTATE_EN adds a rotate input.  Rev 1.0
`default_nettype none

module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   input  logic             rotate,
`endif
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   input  logic [WIDTH-1:0] par_in,
   output logic [WIDTH-1:0] par_out,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             word_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mode_t            eff_mode;
   logic [WIDTH-1:0] q;
   logic             ser_r;
   logic             ser_l;
   logic [WIDTH:0]   hi_chain;
   logic [WIDTH:0]   lo_chain;

   assign eff_mode = en ? mode_t'(mode) : MODE_HOLD;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   assign ser_r = rotate ? q[0]       : sin_msb;
   assign ser_l = rotate ? q[WIDTH-1] : sin_lsb;
`else
   assign ser_r = sin_msb;
   assign ser_l = sin_lsb;
`endif

   // Padded neighbour chains: bit i takes hi_chain[i+1] on right shift, lo_chain[i] on left shift.
   assign hi_chain = {ser_r, q};
   assign lo_chain = {q, ser_l};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      shift_reg_cell u_cell (
         .clk      (clk),
         .reset    (reset),
         .sel      (eff_mode),
         .from_hi  (hi_chain[i+1]),
         .from_lo  (lo_chain[i]),
         .load_bit (par_in[i]),
         .q        (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_cnt <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         case (eff_mode)
            MODE_LOAD: shift_cnt <= '0;
            MODE_SHR, MODE_SHL: begin
               if (shift_cnt == CNT_LAST) begin
                  shift_cnt <= '0;
                  word_done <= 1'b1;
               end else begin
                  shift_cnt <= shift_cnt + 1'b1;
               end
            end
            default: shift_cnt <= shift_cnt;
         endcase
      end
   end

   assign par_out  = q;
   assign sout_lsb = q[0];
   assign sout_msb = q[WIDTH-1];

endmodule

`default_nettype wire
